video_timing: RTL
=================

Name: video_timing

Overview:
- Generates raster timing for the System 86 video path from the 6 MHz pixel clock.
- Produces H/V counters, sync, blanking and the VRES/HSYNC strobes consumed directly by the cus35 scroll/address stage.
- Also provides a frame-synchronous latched FLIP, a vblank CPU interrupt strobe and a frame counter.
- Sits directly upstream of cus35 and the other tile/sprite address generators.

Parameters:
- H_TOTAL, 384, pixel clocks per line
- H_ACTIVE, 288, visible pixels per line (H = 0..H_ACTIVE-1)
- H_SYNC_START, 320, first H count with HSYNC asserted
- H_SYNC_LEN, 32, HSYNC width in clocks
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines (V = 0..V_ACTIVE-1)
- V_SYNC_START, 240, first line with VSYNC asserted
- V_SYNC_LEN, 8, VSYNC width in lines

Ports:
- CLK_6M  in  1  pixel clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- FLIP_REQ  in  1  requested screen flip (CPU latch, asynchronous to frame)
- H  out  9  horizontal count, 0..H_TOTAL-1
- V  out  9  vertical count, 0..V_TOTAL-1
- HF  out  9  H, or H_ACTIVE-1-H when FLIP=1 and H<H_ACTIVE
- VF  out  9  V, or V_ACTIVE-1-V when FLIP=1 and V<V_ACTIVE
- HSYNC  out  1  active-high horizontal sync
- VSYNC  out  1  active-high vertical sync
- HBLANK  out  1  high when H>=H_ACTIVE
- VBLANK  out  1  high when V>=V_ACTIVE
- VRES  out  1  high for the whole line V==V_TOTAL-1 (vertical reset for cus35)
- FLIP  out  1  FLIP_REQ sampled at frame start
- VBL_IRQ  out  1  one-clock pulse on the first clock of line V_ACTIVE
- FRAME  out  8  frame counter

Behaviour:
- Reset (RST_N low, asynchronous):
  - H=0, V=0, HF=0, VF=0, FLIP=0, FRAME=0.
  - HSYNC, VSYNC, HBLANK, VBLANK, VRES and VBL_IRQ all 0.
  - Counting starts on the first rising edge after RST_N deasserts. That edge takes H to 1.
- Counters:
  - H increments every clock. When H==H_TOTAL-1 it wraps to 0 and V advances.
  - V wraps from V_TOTAL-1 to 0. At that wrap FRAME increments, modulo 256.
- Timing and alignment:
  - All outputs are registered and computed from next-state counter values.
  - Every decoded output is therefore consistent with H/V in the same cycle, with zero relative latency.
- Decode rules:
  - HSYNC = (H >= H_SYNC_START) and (H < H_SYNC_START+H_SYNC_LEN).
  - VSYNC = (V >= V_SYNC_START) and (V < V_SYNC_START+V_SYNC_LEN), held for whole lines.
  - VSYNC, VBLANK and VRES change only on the H wrap edge.
- FLIP handling:
  - FLIP_REQ passes through a 2-flop synchroniser.
  - The synchronised value loads into FLIP only on the edge where H and V both wrap to 0.
  - A FLIP_REQ change mid-frame has no effect until the next frame start.
- Flipped counters:
  - HF/VF arithmetic is 9-bit unsigned.
  - In blanking regions HF and VF pass H and V through unmodified, flip or not.
- VBL_IRQ: high exactly one clock, in the cycle where V becomes V_ACTIVE and H becomes 0.
- Parameter sanity:
  - Required: H_SYNC_START+H_SYNC_LEN <= H_TOTAL and V_SYNC_START+V_SYNC_LEN <= V_TOTAL.
  - Required: H_ACTIVE <= H_SYNC_START and V_ACTIVE <= V_SYNC_START.
  - Any violation is a simulation-time error via an initial check.
- Reset mid-frame: all state returns to reset values immediately. No partial sync pulse may be held.

Decomposition:
- Package system86_video_pkg holds:
  - the default timing constants (384/288/320/32, 264/224/240/8);
  - the 9-bit counter width constant;
  - a function for the flip-mirror computation.
- One sub-module is natural: mod_counter.
  - Parameterised modulus and width, with enable input, wrap/carry output and async active-low reset.
  - Instantiated twice: H with enable=1; V with enable = H carry.

Test Plan:
- Release reset, run 384 clocks:
  - H goes 0..383 and returns to 0; V steps 0->1 on that edge.
  - HBLANK rises at H=288; HSYNC is high for H=320..351 (32 clocks).
- Run a full frame of 384*264 = 101376 clocks:
  - VBLANK covers V=224..263.
  - VSYNC is high for lines 240..247.
  - VRES is high for all 384 clocks of line 263.
  - FRAME goes 0->1 at the V wrap.
- Count VBL_IRQ over 3 frames: exactly 3 single-cycle pulses, each at V=224, H=0.
- FLIP behaviour:
  - Assert FLIP_REQ at V=100: FLIP stays 0 until the next H=0,V=0, then goes to 1.
  - At H=0,V=0 after that, HF=287 and VF=223.
  - At H=300, HF=300.
- Assert RST_N low at H=330, V=245:
  - HSYNC, VSYNC and all counters drop to 0 asynchronously, before the next clock edge.
  - After release, timing restarts from H=0,V=0.
- Run 256 frames: FRAME wraps 255->0 with no glitch on the other outputs.

Source files
------------

// File: rtl/system86_video_pkg.sv
// Shared timing constants and helpers for the System 86 raster generator.
// Imported by the counter, the top level and the bench.
package system86_video_pkg;

    localparam int CNT_W = 9;
    localparam int FRAME_W = 8;

    localparam int DEF_H_TOTAL      = 384;
    localparam int DEF_H_ACTIVE     = 288;
    localparam int DEF_H_SYNC_START = 320;
    localparam int DEF_H_SYNC_LEN   = 32;

    localparam int DEF_V_TOTAL      = 264;
    localparam int DEF_V_ACTIVE     = 224;
    localparam int DEF_V_SYNC_START = 240;
    localparam int DEF_V_SYNC_LEN   = 8;

    // Mirror a count inside the active window only; blanking counts pass through.
    function automatic logic [CNT_W-1:0] flip_mirror(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] active,
        input logic             flip
    );
        if (flip && (val < active)) begin
            return active - val - CNT_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable. It exposes the registered count, the value
// it will load on the next edge, and a wrap flag for cascading.
module mod_counter #(
    parameter int MODULUS = 384,
    parameter int WIDTH   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS %0d does not fit WIDTH %0d", MODULUS, WIDTH);
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        wrap = en && (count == LAST);
        next = count;
        if (en) begin
            next = wrap ? '0 : count + WIDTH'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order of the statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: H/V counters plus registered sync, blank, VRES,
// frame-latched FLIP with mirrored counters, vblank IRQ strobe and frame count.
module video_timing
    import system86_video_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input  logic               CLK_6M,
    input  logic               RST_N,
    input  logic               FLIP_REQ,
    output logic [CNT_W-1:0]   H,
    output logic [CNT_W-1:0]   V,
    output logic [CNT_W-1:0]   HF,
    output logic [CNT_W-1:0]   VF,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               HBLANK,
    output logic               VBLANK,
    output logic               VRES,
    output logic               FLIP,
    output logic               VBL_IRQ,
    output logic [FRAME_W-1:0] FRAME
);

    if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_h_sync
        $error("video_timing: HSYNC window runs past H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_v_sync
        $error("video_timing: VSYNC window runs past V_TOTAL");
    end
    if (H_ACTIVE > H_SYNC_START) begin : g_bad_h_active
        $error("video_timing: H_ACTIVE overlaps HSYNC");
    end
    if (V_ACTIVE > V_SYNC_START) begin : g_bad_v_active
        $error("video_timing: V_ACTIVE overlaps VSYNC");
    end

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;
    logic             v_wrap;
    logic [1:0]       flip_sync;

    logic             flip_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             hblank_next;
    logic             vblank_next;
    logic             vres_next;
    logic             irq_next;

    mod_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (CNT_W)
    ) u_h_count (
        .clk   (CLK_6M),
        .rst_n (RST_N),
        .en    (1'b1),
        .count (H),
        .next  (h_next),
        .wrap  (h_wrap)
    );

    mod_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (CNT_W)
    ) u_v_count (
        .clk   (CLK_6M),
        .rst_n (RST_N),
        .en    (h_wrap),
        .count (V),
        .next  (v_next),
        .wrap  (v_wrap)
    );

    // Decode from next-state counts so the registered strobes line up with H/V.
    always_comb begin
        flip_next   = v_wrap ? flip_sync[1] : FLIP;
        hsync_next  = (h_next >= HS_BEG) && (h_next < HS_END);
        vsync_next  = (v_next >= VS_BEG) && (v_next < VS_END);
        hblank_next = (h_next >= H_ACT);
        vblank_next = (v_next >= V_ACT);
        vres_next   = (v_next == V_LAST);
        irq_next    = h_wrap && (v_next == V_ACT);
    end

    always_ff @(posedge CLK_6M or negedge RST_N) begin
        if (!RST_N) begin
            flip_sync <= '0;
            FLIP      <= 1'b0;
            HF        <= '0;
            VF        <= '0;
            HSYNC     <= 1'b0;
            VSYNC     <= 1'b0;
            HBLANK    <= 1'b0;
            VBLANK    <= 1'b0;
            VRES      <= 1'b0;
            VBL_IRQ   <= 1'b0;
            FRAME     <= '0;
        end else begin
            flip_sync <= {flip_sync[0], FLIP_REQ};
            FLIP      <= flip_next;
            HF        <= flip_mirror(h_next, H_ACT, flip_next);
            VF        <= flip_mirror(v_next, V_ACT, flip_next);
            HSYNC     <= hsync_next;
            VSYNC     <= vsync_next;
            HBLANK    <= hblank_next;
            VBLANK    <= vblank_next;
            VRES      <= vres_next;
            VBL_IRQ   <= irq_next;
            if (v_wrap) begin
                FRAME <= FRAME + FRAME_W'(1);
            end
        end
    end

endmodule
